// File: rtl/sop_accumulator.sv
// Multi-beat saturating sum-of-products accumulator with valid/ready result hold.
// Optional build macro SOP_RELU_EN clamps negative results to zero on out_sum.
module sop_accumulator #(
  parameter int unsigned z     = 4,
  parameter int unsigned width = 16,
  parameter int unsigned beats = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width*z-1:0]       prod_set,
  input  logic [width-1:0]         bias,
  output logic [$clog2(beats)-1:0] beat_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width-1:0]         out_sum
);

  localparam int unsigned IdxW = $clog2(beats);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(beats - 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [width-1:0] acc_q, acc_d;
  logic [width-1:0] sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [width-1:0] tree_sum;
  logic [width-1:0] base;
  logic [width-1:0] step;
  logic             accept;

  function automatic logic [width-1:0] sat_add(input logic [width-1:0] a,
                                               input logic [width-1:0] b);
    logic [width-1:0] s;
    s = a + b;
    if ((a[width-1] == b[width-1]) && (s[width-1] != a[width-1])) begin
      s = a[width-1] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
    end
    return s;
  endfunction

  function automatic logic [width-1:0] result_clamp(input logic [width-1:0] v);
`ifdef SOP_RELU_EN
    return v[width-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Heap-ordered tree: leaves at z..2z-1, node k = sat(node 2k, node 2k+1), root at 1.
  always_comb begin
    logic [width-1:0] node [1:2*z-1];
    for (int i = 0; i < int'(z); i++) begin
      node[int'(z) + i] = prod_set[width*i +: width];
    end
    for (int k = int'(z) - 1; k >= 1; k--) begin
      node[k] = sat_add(node[2*k], node[2*k+1]);
    end
    tree_sum = node[1];
  end

  assign out_valid = (state_q == StHold);
  assign in_ready  = ~out_valid;
  assign beat_idx  = idx_q;
  assign out_sum   = sum_q;

  assign accept = in_valid & in_ready & ~flush;
  assign base   = (idx_q == '0) ? bias : acc_q;
  assign step   = sat_add(base, tree_sum);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    unique case (state_q)
      StAccum: begin
        if (flush) begin
          acc_d = '0;
          idx_d = '0;
        end else if (accept) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            sum_d   = result_clamp(step);
            state_d = StHold;
          end else begin
            acc_d = step;
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StHold: begin
        if (out_ready) state_d = StAccum;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StAccum;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

endmodule
